// File: rtl/tff_toggle_ctrl_if.sv
// Command channel for tff_toggle_ctrl: valid/ready handshake carrying
// {mask, count}, plus the asynchronous-to-protocol abort request.
interface tff_toggle_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;

  // Command source side
  modport master (
    output cmd_valid,
    output cmd_mask,
    output cmd_count,
    output abort,
    input  cmd_ready
  );

  // Controller side
  modport slave (
    input  cmd_valid,
    input  cmd_mask,
    input  cmd_count,
    input  abort,
    output cmd_ready
  );
endinterface

// File: rtl/tff_toggle_ctrl.sv
// Pulse sequencer for a bank of WIDTH T flip-flops. Accepts {mask, count}
// commands, issues `count` one-cycle toggle enables spaced by GAP idle
// cycles, and tracks the expected flop state in q_mirror.
// Optional: define TFF_CTRL_STATS_EN to add a saturating stat_pulses counter.
module tff_toggle_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  tff_toggle_ctrl_if.slave cmd,
  output logic [WIDTH-1:0] tog_en,
  output logic [WIDTH-1:0] q_mirror,
  output logic             busy,
  output logic             done
`ifdef TFF_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_pulses
`endif
);

  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  // Gap counter load value; unused when GAP == 0 (pulses run back-to-back)
  localparam logic [GapW-1:0] GapLoad = (GAP > 0) ? GapW'(GAP - 1) : '0;

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [WIDTH-1:0] mirror_q, mirror_d;

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
      mirror_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      mirror_q <= mirror_d;
    end
  end

  // Next-state logic; abort takes priority over rem/gap transitions
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    mirror_d = mirror_q;
    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          mask_d  = cmd.cmd_mask;
          rem_d   = cmd.cmd_count;
          state_d = (cmd.cmd_count == '0) ? StDone : StPulse;
        end
      end
      StPulse: begin
        // The pulse visible this cycle always lands, even if aborted
        mirror_d = mirror_q ^ mask_q;
        rem_d    = rem_q - 1'b1;
        if (cmd.abort || (rem_q == CNT_W'(1))) begin
          state_d = StDone;
        end else if (GAP == 0) begin
          state_d = StPulse;
        end else begin
          state_d = StGap;
          gap_d   = GapLoad;
        end
      end
      StGap: begin
        if (cmd.abort) begin
          state_d = StDone;
        end else if (gap_q == '0) begin
          state_d = StPulse;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded purely from registers
  always_comb begin
    cmd.cmd_ready = (state_q == StIdle);
    busy          = (state_q == StPulse) || (state_q == StGap);
    done          = (state_q == StDone);
    tog_en        = (state_q == StPulse) ? mask_q : '0;
    q_mirror      = mirror_q;
  end

`ifdef TFF_CTRL_STATS_EN
  logic [15:0] stat_q;

  // Saturating count of PULSE cycles since reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else if ((state_q == StPulse) && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_pulses = stat_q;
`endif

endmodule

// File: tb/tb_tff_toggle_ctrl.sv
// Bench for tff_toggle_ctrl: directed vector table, hand-written corner
// sequences (reset mid-command, GAP=0 instance) and a randomized run checked
// against a schedule-based reference model.
module tb_tff_toggle_ctrl;

  localparam int unsigned TbGap = 2;

  logic clk;
  logic reset;

  tff_toggle_ctrl_if #(.WIDTH(4), .CNT_W(8)) if1 ();
  tff_toggle_ctrl_if #(.WIDTH(4), .CNT_W(8)) if2 ();

  logic [3:0] tog1, mir1, tog2, mir2;
  logic       busy1, done1, busy2, done2;
`ifdef TFF_CTRL_STATS_EN
  logic [15:0] stat1, stat2;
`endif

  tff_toggle_ctrl #(.WIDTH(4), .CNT_W(8), .GAP(TbGap)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .cmd      (if1.slave),
    .tog_en   (tog1),
    .q_mirror (mir1),
    .busy     (busy1),
    .done     (done1)
`ifdef TFF_CTRL_STATS_EN
    ,
    .stat_pulses (stat1)
`endif
  );

  tff_toggle_ctrl #(.WIDTH(4), .CNT_W(8), .GAP(0)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .cmd      (if2.slave),
    .tog_en   (tog2),
    .q_mirror (mir2),
    .busy     (busy2),
    .done     (done2)
`ifdef TFF_CTRL_STATS_EN
    ,
    .stat_pulses (stat2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] m;
    logic [7:0] c;
    logic       ab;
    logic       chk;
    logic [3:0] tog;
    logic [3:0] mir;
    logic       bsy;
    logic       dn;
    logic       rdy;
  } vec_t;

  function automatic vec_t mk(logic rst, logic v, logic [3:0] m, logic [7:0] c, logic ab,
                              logic chk, logic [3:0] tog, logic [3:0] mir, logic bsy,
                              logic dn, logic rdy);
    vec_t r;
    r = '{rst, v, m, c, ab, chk, tog, mir, bsy, dn, rdy};
    return r;
  endfunction

  // One model slot per future cycle of a command
  typedef struct {
    logic [3:0] tog;
    logic       pulse;
    logic       busy;
    logic       done;
  } slot_t;

  vec_t       vecs[$];
  slot_t      sched[$];
  slot_t      cur;
  logic [3:0] m_mir;
  int         m_stat;

  task automatic drive1(logic rst, logic v, logic [3:0] m, logic [7:0] c, logic ab);
    reset         = rst;
    if1.cmd_valid = v;
    if1.cmd_mask  = m;
    if1.cmd_count = c;
    if1.abort     = ab;
  endtask

  initial begin
    drive1(1'b1, 1'b0, 4'h0, 8'd0, 1'b0);
    if2.cmd_valid = 1'b0;
    if2.cmd_mask  = 4'h0;
    if2.cmd_count = 8'd0;
    if2.abort     = 1'b0;

    // Each row: check outputs of the current cycle, then drive inputs for the next edge
    //                    rst  v    m     c     ab   chk  tog   mir   bsy  dn   rdy
    vecs.push_back(mk(1'b1,1'b0,4'h0,8'd0,1'b0,1'b0,4'h0,4'h0,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h0,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h0,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'h5,8'd3,1'b0,1'b1,4'h0,4'h0,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h5,4'h0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h5,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h5,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h5,4'h5,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h5,4'h0,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h5,1'b0,1'b1,1'b0));
    // count=0 command
    vecs.push_back(mk(1'b0,1'b1,4'hF,8'd0,1'b0,1'b1,4'h0,4'h5,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h5,1'b0,1'b1,1'b0));
    // count=5, abort in first gap cycle
    vecs.push_back(mk(1'b0,1'b1,4'h3,8'd5,1'b0,1'b1,4'h0,4'h5,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h3,4'h5,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b1,1'b1,4'h0,4'h6,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'h6,1'b0,1'b1,1'b0));
    // abort together with cmd_valid in idle: command still accepted
    vecs.push_back(mk(1'b0,1'b1,4'h8,8'd1,1'b1,1'b1,4'h0,4'h6,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h8,4'h6,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'hE,1'b0,1'b1,1'b0));
    // abort during a pulse: that pulse still lands
    vecs.push_back(mk(1'b0,1'b1,4'h1,8'd3,1'b0,1'b1,4'h0,4'hE,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b1,1'b1,4'h1,4'hE,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'hF,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'h0,8'd0,1'b0,1'b1,4'h0,4'hF,1'b0,1'b0,1'b1));

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_tog_en", i), tog1, vecs[i].tog);
        check($sformatf("vec%0d_q_mirror", i), mir1, vecs[i].mir);
        check($sformatf("vec%0d_busy", i), busy1, vecs[i].bsy);
        check($sformatf("vec%0d_done", i), done1, vecs[i].dn);
        check($sformatf("vec%0d_cmd_ready", i), if1.cmd_ready, vecs[i].rdy);
      end
      drive1(vecs[i].rst, vecs[i].v, vecs[i].m, vecs[i].c, vecs[i].ab);
    end
`ifdef TFF_CTRL_STATS_EN
    check("vec_stat_pulses", stat1, 32'd6);
`endif

    // Reset during the gap of a count=4 command
    @(negedge clk);
    drive1(1'b0, 1'b1, 4'h2, 8'd4, 1'b0);
    @(negedge clk);
    drive1(1'b0, 1'b0, 4'h0, 8'd0, 1'b0);
    check("rst_mid_pulse", tog1, 32'h2);
    @(negedge clk);
    check("rst_mid_gap_busy", busy1, 32'd1);
    drive1(1'b1, 1'b0, 4'h0, 8'd0, 1'b0);
    @(negedge clk);
    drive1(1'b0, 1'b0, 4'h0, 8'd0, 1'b0);
    check("rst_mid_busy", busy1, 32'd0);
    check("rst_mid_done", done1, 32'd0);
    check("rst_mid_mirror", mir1, 32'h0);
    check("rst_mid_ready", if1.cmd_ready, 32'd1);
    @(negedge clk);
    check("rst_mid_no_done", done1, 32'd0);
    check("rst_mid_tog", tog1, 32'h0);

    // GAP=0 instance: back-to-back pulses
    if2.cmd_valid = 1'b1;
    if2.cmd_mask  = 4'hF;
    if2.cmd_count = 8'd4;
    check("gap0_ready", if2.cmd_ready, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if2.cmd_valid = 1'b0;
      check($sformatf("gap0_tog%0d", i), tog2, 32'hF);
      check($sformatf("gap0_mir%0d", i), mir2, (i % 2 == 1) ? 32'hF : 32'h0);
    end
    @(negedge clk);
    check("gap0_done", done2, 32'd1);
    check("gap0_tog_off", tog2, 32'h0);
    check("gap0_mirror", mir2, 32'h0);
`ifdef TFF_CTRL_STATS_EN
    check("gap0_stat_pulses", stat2, 32'd4);
`endif

    // Randomized run against a per-cycle schedule model
    @(negedge clk);
    drive1(1'b1, 1'b0, 4'h0, 8'd0, 1'b0);
    sched.delete();
    m_mir  = 4'h0;
    m_stat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       r_rst, r_v, r_ab, idle;
      logic [3:0] r_m;
      logic [7:0] r_c;
      @(negedge clk);
      idle = (sched.size() == 0);
      if (idle) cur = '{4'h0, 1'b0, 1'b0, 1'b0};
      else      cur = sched[0];
      check("rnd_tog_en", tog1, cur.tog);
      check("rnd_busy", busy1, cur.busy);
      check("rnd_done", done1, cur.done);
      check("rnd_cmd_ready", if1.cmd_ready, idle);
      check("rnd_q_mirror", mir1, m_mir);
`ifdef TFF_CTRL_STATS_EN
      check("rnd_stat_pulses", stat1, m_stat);
`endif
      r_rst = ($urandom_range(0, 199) == 0);
      r_v   = ($urandom_range(0, 3) == 0);
      r_m   = 4'($urandom);
      r_c   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      r_ab  = ($urandom_range(0, 11) == 0);
      drive1(r_rst, r_v, r_m, r_c, r_ab);
      if (r_rst) begin
        sched.delete();
        m_mir  = 4'h0;
        m_stat = 0;
      end else if (!idle) begin
        if (cur.pulse) begin
          m_mir = m_mir ^ cur.tog;
          if (m_stat < 16'hFFFF) m_stat++;
        end
        sched.delete(0);
        if (cur.busy && r_ab) begin
          sched.delete();
          sched.push_back('{4'h0, 1'b0, 1'b0, 1'b1});
        end
      end else if (r_v) begin
        for (int i = 0; i < int'(r_c); i++) begin
          sched.push_back('{r_m, 1'b1, 1'b1, 1'b0});
          if (i != int'(r_c) - 1) begin
            for (int g = 0; g < int'(TbGap); g++) sched.push_back('{4'h0, 1'b0, 1'b1, 1'b0});
          end
        end
        sched.push_back('{4'h0, 1'b0, 1'b0, 1'b1});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
